// File: rtl/btb_updater.sv
// BTB write-side updater: mispredict redirect plus FIFO-buffered training writes.
// Optional BTB_UPD_BYPASS_EN lets a training entry skip an empty FIFO.
module btb_updater #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_pred_hit,
  input  logic [31:0]      res_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  input  logic             btb_wr_ready,
  output logic             btb_load,
  output logic [31:0]      btb_w_pc,
  output logic [31:0]      btb_target_in,
  output logic [CNT_W-1:0] upd_drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } entry_t;

  entry_t      mem [DEPTH];
  logic [AW:0] head;
  logic [AW:0] tail;

  logic   wrong;
  logic   train;
  logic   empty;
  logic   full;
  logic   pop;
  logic   bypass;
  logic   push;
  logic   drop;
  entry_t in_e;

  assign in_e.pc     = res_pc;
  assign in_e.target = res_target;

  assign wrong = (res_taken != res_pred_hit) ||
                 (res_taken && res_pred_hit &&
                  (res_target != res_pred_target));

  assign train = res_valid && res_taken &&
                 (!res_pred_hit || (res_target != res_pred_target));

  assign empty = (head == tail);
  assign full  = (head[AW] != tail[AW]) &&
                 (head[AW-1:0] == tail[AW-1:0]);
  assign pop   = !empty && btb_wr_ready;

`ifdef BTB_UPD_BYPASS_EN
  assign bypass = empty && btb_wr_ready && train;
`else
  assign bypass = 1'b0;
`endif

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = train && !bypass && (!full || pop);
  assign drop = train && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail[AW-1:0]] <= in_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      btb_load       <= 1'b0;
      btb_w_pc       <= '0;
      btb_target_in  <= '0;
      upd_drop_count <= '0;
    end else begin
      mispredict <= res_valid && wrong;
      if (res_valid && wrong) begin
        redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
      end
      if (push) begin
        tail <= tail + 1'b1;
      end
      btb_load <= pop || bypass;
      if (pop) begin
        head          <= head + 1'b1;
        btb_w_pc      <= mem[head[AW-1:0]].pc;
        btb_target_in <= mem[head[AW-1:0]].target;
      end else if (bypass) begin
        btb_w_pc      <= res_pc;
        btb_target_in <= res_target;
      end
      if (drop && !(&upd_drop_count)) begin
        upd_drop_count <= upd_drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btb_updater.sv
// Directed self-checking bench for btb_updater.
// Honors BTB_UPD_BYPASS_EN for the single bypass-eligible case.
module tb_btb_updater;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_hit;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        btb_wr_ready;
  logic        btb_load;
  logic [31:0] btb_w_pc;
  logic [31:0] btb_target_in;
  logic [15:0] upd_drop_count;

  int checks = 0;
  int errors = 0;

  btb_updater #(.DEPTH(4), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_hit    (res_pred_hit),
    .res_pred_target (res_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .btb_wr_ready    (btb_wr_ready),
    .btb_load        (btb_load),
    .btb_w_pc        (btb_w_pc),
    .btb_target_in   (btb_target_in),
    .upd_drop_count  (upd_drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic res(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg, input logic hit,
                     input logic [31:0] pt);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_taken       = tk;
    res_target      = tg;
    res_pred_hit    = hit;
    res_pred_target = pt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ld(input string tag, input logic [31:0] pc,
                        input logic [31:0] tg);
    chk({tag, "_load"}, {31'd0, btb_load}, 32'd1);
    chk({tag, "_pc"}, btb_w_pc, pc);
    chk({tag, "_tg"}, btb_target_in, tg);
  endtask

  initial begin
    rst = 1'b1;
    res_valid = 1'b0;
    res_pc = '0;
    res_taken = 1'b0;
    res_target = '0;
    res_pred_hit = 1'b0;
    res_pred_target = '0;
    btb_wr_ready = 1'b0;
    tick();
    tick();
    chk("rst_misp", {31'd0, mispredict}, 32'd0);
    chk("rst_redir", redirect_pc, 32'd0);
    chk("rst_load", {31'd0, btb_load}, 32'd0);
    chk("rst_wpc", btb_w_pc, 32'd0);
    chk("rst_drop", {16'd0, upd_drop_count}, 32'd0);
    rst = 1'b0;

    // miss then taken
    btb_wr_ready = 1'b1;
    res(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    res_valid = 1'b0;
    chk("mt_misp", {31'd0, mispredict}, 32'd1);
    chk("mt_redir", redirect_pc, 32'h200);
`ifdef BTB_UPD_BYPASS_EN
    chk_ld("mt_byp", 32'h100, 32'h200);
    tick();
    chk("mt_load1", {31'd0, btb_load}, 32'd0);
`else
    chk("mt_load0", {31'd0, btb_load}, 32'd0);
    tick();
    chk("mt_misp1", {31'd0, mispredict}, 32'd0);
    chk_ld("mt_wr", 32'h100, 32'h200);
`endif
    tick();
    chk("mt_idle", {31'd0, btb_load}, 32'd0);
    chk("mt_hold", redirect_pc, 32'h200);

    // false hit
    res(32'h300, 1'b0, 32'h0, 1'b1, 32'h999);
    tick();
    res_valid = 1'b0;
    chk("fh_misp", {31'd0, mispredict}, 32'd1);
    chk("fh_redir", redirect_pc, 32'h304);
    chk("fh_load0", {31'd0, btb_load}, 32'd0);
    tick();
    chk("fh_misp1", {31'd0, mispredict}, 32'd0);
    chk("fh_load1", {31'd0, btb_load}, 32'd0);

    // wrong target
    btb_wr_ready = 1'b0;
    res(32'h440, 1'b1, 32'h480, 1'b1, 32'h400);
    tick();
    res_valid = 1'b0;
    btb_wr_ready = 1'b1;
    chk("wt_misp", {31'd0, mispredict}, 32'd1);
    chk("wt_redir", redirect_pc, 32'h480);
    chk("wt_load0", {31'd0, btb_load}, 32'd0);
    tick();
    chk_ld("wt_wr", 32'h440, 32'h480);
    tick();
    chk("wt_once", {31'd0, btb_load}, 32'd0);
    res(32'h440, 1'b1, 32'h480, 1'b1, 32'h480);
    tick();
    res_valid = 1'b0;
    chk("ok_misp", {31'd0, mispredict}, 32'd0);
    chk("ok_hold", redirect_pc, 32'h480);
    chk("ok_load0", {31'd0, btb_load}, 32'd0);
    tick();
    chk("ok_load1", {31'd0, btb_load}, 32'd0);

    // overflow: six pushes into four slots
    btb_wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      res(32'h1000 + 32'(i) * 32'h10, 1'b1,
          32'h2000 + 32'(i) * 32'h10, 1'b0, 32'h0);
      tick();
    end
    res_valid = 1'b0;
    chk("ov_drop", {16'd0, upd_drop_count}, 32'd2);
    chk("ov_load", {31'd0, btb_load}, 32'd0);
    btb_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ld($sformatf("ov_d%0d", i), 32'h1000 + 32'(i) * 32'h10,
             32'h2000 + 32'(i) * 32'h10);
    end
    tick();
    chk("ov_end", {31'd0, btb_load}, 32'd0);
    chk("ov_drop2", {16'd0, upd_drop_count}, 32'd2);

    // full with simultaneous push and pop
    btb_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res(32'h600 + 32'(i) * 32'h10, 1'b1,
          32'h700 + 32'(i) * 32'h10, 1'b0, 32'h0);
      tick();
    end
    btb_wr_ready = 1'b1;
    res(32'h500, 1'b1, 32'h550, 1'b0, 32'h0);
    tick();
    res_valid = 1'b0;
    chk_ld("fs_d0", 32'h600, 32'h700);
    chk("fs_drop", {16'd0, upd_drop_count}, 32'd2);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_ld($sformatf("fs_d%0d", i), 32'h600 + 32'(i) * 32'h10,
             32'h700 + 32'(i) * 32'h10);
    end
    tick();
    chk_ld("fs_last", 32'h500, 32'h550);
    tick();
    chk("fs_end", {31'd0, btb_load}, 32'd0);

    // reset mid-drain
    btb_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res(32'h800 + 32'(i) * 32'h10, 1'b1,
          32'h900 + 32'(i) * 32'h10, 1'b0, 32'h0);
      tick();
    end
    res_valid = 1'b0;
    btb_wr_ready = 1'b1;
    tick();
    chk_ld("rd_d0", 32'h800, 32'h900);
    rst = 1'b1;
    res(32'hA00, 1'b1, 32'hB00, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    res_valid = 1'b0;
    chk("rd_load", {31'd0, btb_load}, 32'd0);
    chk("rd_drop", {16'd0, upd_drop_count}, 32'd0);
    chk("rd_misp", {31'd0, mispredict}, 32'd0);
    chk("rd_redir", redirect_pc, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rd_quiet%0d", i), {31'd0, btb_load}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_updater.md
Name: btb_updater

Overview:
- Write-side companion of the branch target buffer.
- Takes resolved branch outcomes from the execute stage and detects mispredictions against the fetch-time BTB prediction.
- Issues a registered redirect to fetch on a misprediction.
- Queues BTB training writes in a small FIFO and drains them one per cycle into the BTB write port (load / w_pc / target_in) when the port grants.

Parameters:
- DEPTH, 4, training FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the saturating dropped-update counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  resolved branch/jump present this cycle.
- res_pc  in  32  PC of the resolved instruction.
- res_taken  in  1  actual direction; jumps drive 1.
- res_target  in  32  actual taken target.
- res_pred_hit  in  1  BTB hit recorded at fetch (predicted taken).
- res_pred_target  in  32  BTB target recorded at fetch.
- mispredict  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  correct next PC; valid while mispredict=1.
- btb_wr_ready  in  1  BTB write port may accept a write this cycle.
- btb_load  out  1  BTB write strobe.
- btb_w_pc  out  32  BTB write PC.
- btb_target_in  out  32  BTB write target.
- upd_drop_count  out  CNT_W  training entries lost because the FIFO was full.

Behaviour:
- Reset: all outputs 0; FIFO empty; head and tail pointers 0. Reset overrides any same-cycle res_valid or pop.
- Mispredict, evaluated on an edge where res_valid=1:
  - wrong = (res_taken != res_pred_hit) OR (res_taken AND res_pred_hit AND res_target != res_pred_target).
  - If wrong, mispredict=1 for exactly the next cycle.
  - redirect_pc = res_taken ? res_target : res_pc + 4 (mod 2^32).
  - Otherwise mispredict=0 and redirect_pc holds its last value.
- Train condition: res_valid AND res_taken AND (!res_pred_hit OR res_target != res_pred_target).
  - Not-taken outcomes never write; the BTB has no invalidate.
  - When true, push {res_pc, res_target} at the edge.
- Pop: on an edge where FIFO non-empty AND btb_wr_ready=1.
  - Next cycle: btb_load=1, btb_w_pc / btb_target_in = head entry.
  - Otherwise btb_load=0 and the data outputs hold.
- btb_load is high for one cycle per popped entry. Back-to-back pops give consecutive strobes.
- Latency, input sampled at edge E0: entry in FIFO after E0, popped at E1, btb_load high in the cycle after E1.
- Empty: no pop; btb_load=0; btb_wr_ready ignored.
- Full, push with no same-edge pop: entry discarded; upd_drop_count += 1, saturating at all-ones.
- Full, push with a same-edge pop: push accepted, no drop, occupancy unchanged.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy count.
- Order: FIFO order is strict; duplicate PCs are not merged. The BTB applies last-write-wins.
- btb_wr_ready may drop at any time; entries wait without loss.

Optional Feature:
- Macro: BTB_UPD_BYPASS_EN.
- Defined: if FIFO empty, btb_wr_ready=1 and the train condition holds at E0, the entry skips the FIFO. btb_load=1 with that entry in the cycle after E0, one cycle earlier than normal. FIFO occupancy is unchanged.
- Not defined: every training entry passes through the FIFO; latency as specified above.

Test Plan:
- Reset mid-drain: 3 entries queued, rst=1 for one edge -> btb_load=0 next cycle, no further strobes, upd_drop_count=0, mispredict=0.
- Miss then taken: res_pc=0x100, taken, target=0x200, pred_hit=0 -> mispredict pulse, redirect_pc=0x200; btb_load=1, w_pc=0x100, target_in=0x200 in cycle after E1 (cycle after E0 with BTB_UPD_BYPASS_EN).
- False hit: res_pc=0x300, not taken, pred_hit=1 -> mispredict, redirect_pc=0x304; no btb_load.
- Wrong target: taken, target=0x480, pred_hit=1, pred_target=0x400 -> mispredict, redirect_pc=0x480, one write of 0x480. Repeat with pred_target=0x480 -> no pulse, no write.
- Overflow: btb_wr_ready=0, six consecutive training pushes with DEPTH=4 -> upd_drop_count=2. Then raise ready -> four strobes in push order, carrying the first four PCs.
- Full with simultaneous push+pop: FIFO full, ready=1, push 0x500 -> no drop; 0x500 drained last.
